ahbl_wait_mem_slave: RTL and testbench

AHB-Lite slave memory with programmable wait states and ERROR signalling. It sits directly downstream of the AHB-Lite BFM master on the bus and consumes the transfers the master issues. It gives vector-driven tests a known-good target for OKAY, wait-state, back-to-back pipelined and ERROR response paths. Storage is a little-endian 32-bit word array with byte, halfword and word write strobes.

---
 rtl/ahbl_wait_mem_slave.sv | 236 +++++++++++++++++++++++
 tb/tb_ahbl_wait_mem_slave.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahbl_wait_mem_slave.sv
// -----------------------------------------------------------------------------
// ahbl_wait_mem_slave
//
// AHB-Lite slave backed by a little-endian 32-bit word memory. Every OKAY
// data phase is stretched by WAIT_STATES cycles. Illegal accesses get the
// two-cycle ERROR response. Back-to-back pipelined transfers are accepted in
// the final data-phase cycle of the previous transfer, so there is no bubble.
//
// Parameters
//   AWIDTH       word-address bits; the memory holds 2^AWIDTH words
//   WAIT_STATES  HREADYOUT-low cycles per OKAY data phase (0..15)
//
// Ports
//   i_hclk        clock; all state changes on the rising edge
//   i_hresetn     synchronous active-low reset (memory contents are kept)
//   i_hsel        slave select
//   i_haddr       address-phase byte address
//   i_htrans      transfer type (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11)
//   i_hwrite      1 = write
//   i_hsize       0 = byte, 1 = halfword, 2 = word
//   i_hwdata      write data, sampled in the final data-phase cycle
//   i_hreadyin    bus HREADY (previous transfer on the bus has completed)
//   o_hreadyout   data-phase completion
//   o_hresp       0 = OKAY, 1 = ERROR
//   o_hrdata      read data; zero except in the final cycle of a read
// -----------------------------------------------------------------------------
module ahbl_wait_mem_slave #(
  parameter int AWIDTH      = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic        i_hclk,
  input  logic        i_hresetn,
  input  logic        i_hsel,
  input  logic [31:0] i_haddr,
  input  logic [1:0]  i_htrans,
  input  logic        i_hwrite,
  input  logic [2:0]  i_hsize,
  input  logic [31:0] i_hwdata,
  input  logic        i_hreadyin,
  output logic        o_hreadyout,
  output logic        o_hresp,
  output logic [31:0] o_hrdata
);

  localparam int DEPTH = 1 << AWIDTH;

  // FSM encoding
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd1;
  localparam logic [2:0] ST_DONE = 3'd2;
  localparam logic [2:0] ST_ERR1 = 3'd3;
  localparam logic [2:0] ST_ERR2 = 3'd4;

  localparam logic [2:0] SZ_BYTE = 3'd0;
  localparam logic [2:0] SZ_HALF = 3'd1;
  localparam logic [2:0] SZ_WORD = 3'd2;

  // The counter is loaded with WAIT_STATES-1 and DONE is entered after the
  // cycle in which it reads zero, giving exactly WAIT_STATES low cycles.
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [2:0]        r_state;
  logic [3:0]        r_cnt;
  logic [AWIDTH+1:0] r_addr;
  logic              r_write;
  logic [2:0]        r_size;
  logic              r_hreadyout;
  logic              r_hresp;
  logic [31:0]       r_hrdata;
  logic [31:0]       r_mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Combinational signals
  // ---------------------------------------------------------------------------
  logic [2:0]        w_state_nxt;
  logic [3:0]        w_cnt_nxt;
  logic              w_slot_open;
  logic              w_accept;
  logic              w_addr_err;
  logic [AWIDTH+1:0] w_nxt_addr;
  logic              w_nxt_write;
  logic [2:0]        w_nxt_size;
  logic              w_rd_next;
  logic              w_commit;
  logic [3:0]        w_be;
  logic [AWIDTH-1:0] w_wr_idx;
  logic [AWIDTH-1:0] w_rd_idx;
  logic [31:0]       w_rd_word;
  logic [31:0]       w_fwd_word;

  // HTRANS[0] only separates NONSEQ from SEQ, which this slave treats alike.
  logic w_unused;
  assign w_unused = i_htrans[0];

  // ---------------------------------------------------------------------------
  // Address phase
  // ---------------------------------------------------------------------------
  // A new address phase can only be taken in a cycle where this slave is
  // not stretching a data phase of its own.
  assign w_slot_open = (r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR2);
  assign w_accept    = w_slot_open && i_hsel && i_htrans[1] && i_hreadyin;

  // NOTE: every always_comb output gets a default before any branch; a path
  // that leaves a signal unassigned would otherwise infer a latch.
  always_comb begin
    w_addr_err = 1'b0;
    if ((i_haddr >> (AWIDTH + 2)) != 32'd0)                 w_addr_err = 1'b1;
    if (i_hsize > SZ_WORD)                                  w_addr_err = 1'b1;
    if ((i_hsize == SZ_HALF) && i_haddr[0])                 w_addr_err = 1'b1;
    if ((i_hsize == SZ_WORD) && (i_haddr[1:0] != 2'b00))    w_addr_err = 1'b1;
  end

  // Transfer attributes are held for the whole data phase and replaced only
  // when a new transfer is accepted.
  assign w_nxt_addr  = w_accept ? i_haddr[AWIDTH+1:0] : r_addr;
  assign w_nxt_write = w_accept ? i_hwrite            : r_write;
  assign w_nxt_size  = w_accept ? i_hsize             : r_size;

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERR2: begin
        if (w_accept) begin
          if (w_addr_err) begin
            w_state_nxt = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = WAIT_LOAD;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      ST_ERR1: w_state_nxt = ST_ERR2;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Write path
  // ---------------------------------------------------------------------------
  // Byte lanes of the transfer in DONE. Error transfers never reach DONE, so
  // the fall-through only ever sees a legal word access.
  always_comb begin
    w_be = 4'b0000;
    case (r_size)
      SZ_BYTE: w_be = 4'b0001 << r_addr[1:0];
      SZ_HALF: w_be = r_addr[1] ? 4'b1100 : 4'b0011;
      default: w_be = 4'b1111;
    endcase
  end

  // A write commits on the edge that closes its DONE cycle. Reset on that
  // same edge aborts the transfer, so the write is dropped.
  assign w_commit = (r_state == ST_DONE) && r_write && i_hresetn;
  assign w_wr_idx = r_addr[AWIDTH+1:2];

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  // Read data is registered on the edge that enters DONE. With no wait
  // states that is also the edge committing a preceding write, so the new
  // bytes of a same-word write are merged over the stale array word.
  assign w_rd_next = (w_state_nxt == ST_DONE) && !w_nxt_write;
  assign w_rd_idx  = w_nxt_addr[AWIDTH+1:2];
  assign w_rd_word = r_mem[w_rd_idx];

  always_comb begin
    w_fwd_word = w_rd_word;
    if (w_commit && (w_wr_idx == w_rd_idx)) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) w_fwd_word[8*b +: 8] = i_hwdata[8*b +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_hclk) begin
    if (!i_hresetn) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 4'd0;
      r_addr      <= '0;
      r_write     <= 1'b0;
      r_size      <= SZ_BYTE;
      r_hreadyout <= 1'b1;
      r_hresp     <= 1'b0;
      r_hrdata    <= 32'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_addr      <= w_nxt_addr;
      r_write     <= w_nxt_write;
      r_size      <= w_nxt_size;
      // Outputs are decoded from the next state and registered, so they
      // change only on the clock edge.
      r_hreadyout <= (w_state_nxt != ST_WAIT) && (w_state_nxt != ST_ERR1);
      r_hresp     <= (w_state_nxt == ST_ERR1) || (w_state_nxt == ST_ERR2);
      r_hrdata    <= w_rd_next ? w_fwd_word : 32'd0;
    end
  end

  // NOTE: the memory array has no reset; its contents survive HRESETN and
  // leaving it out keeps it mappable onto RAM macros.
  always_ff @(posedge i_hclk) begin
    if (w_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_wr_idx][8*b +: 8] <= i_hwdata[8*b +: 8];
      end
    end
  end

  assign o_hreadyout = r_hreadyout;
  assign o_hresp     = r_hresp;
  assign o_hrdata    = r_hrdata;

endmodule

// File: tb/tb_ahbl_wait_mem_slave.sv
// -----------------------------------------------------------------------------
// tb_ahbl_wait_mem_slave
//
// Two slaves share one AHB-Lite bus: index 0 has WAIT_STATES=2, index 1 has
// WAIT_STATES=0. A master task drives pipelined address/data phases to the
// selected slave. Each issued transfer pushes its expected response, taken
// from a byte-level reference memory, into a scoreboard queue. An
// independent monitor watches the selected slave's outputs, measures every
// data phase and pops/compares when the phase completes.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ahbl_wait_mem_slave;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          waits;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hsel_bus;
  logic [1:0]  htrans;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        stall;
  int          cur;
  logic        mon_en;

  logic        ro0, rp0, ro1, rp1;
  logic [31:0] rd0, rd1;
  logic        hsel0, hsel1, hready;

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];
  logic [31:0] ref_mem [2][1024];
  logic dp_active = 1'b0;

  always #5 clk = ~clk;

  assign hsel0  = hsel_bus && (cur == 0);
  assign hsel1  = hsel_bus && (cur == 1);
  // Bus HREADY: an idle slave shows HREADYOUT=1, so the AND follows the
  // slave owning the data phase; stall models another slave holding the bus.
  assign hready = !stall && ro0 && ro1;

  ahbl_wait_mem_slave #(.AWIDTH(10), .WAIT_STATES(2)) u_ws2 (
    .i_hclk(clk), .i_hresetn(rst_n), .i_hsel(hsel0), .i_haddr(haddr),
    .i_htrans(htrans), .i_hwrite(hwrite), .i_hsize(hsize), .i_hwdata(hwdata),
    .i_hreadyin(hready), .o_hreadyout(ro0), .o_hresp(rp0), .o_hrdata(rd0)
  );

  ahbl_wait_mem_slave #(.AWIDTH(10), .WAIT_STATES(0)) u_ws0 (
    .i_hclk(clk), .i_hresetn(rst_n), .i_hsel(hsel1), .i_haddr(haddr),
    .i_htrans(htrans), .i_hwrite(hwrite), .i_hsize(hsize), .i_hwdata(hwdata),
    .i_hreadyin(hready), .o_hreadyout(ro1), .o_hresp(rp1), .o_hrdata(rd1)
  );

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int ws_of(int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic logic [33:0] cur_out();
    return (cur == 0) ? {ro0, rp0, rd0} : {ro1, rp1, rd1};
  endfunction

  // Reference model: apply the access rules to the byte-level memory image
  // in issue order and queue the response the slave must give.
  task automatic model_push(int d, logic [31:0] a, logic wr, logic [2:0] sz, logic [31:0] wd);
    exp_t e;
    int   b;
    e.err = ((a >> 12) != 0) || (sz > 3'd2) || (sz == 3'd1 && a[0]) ||
            (sz == 3'd2 && a[1:0] != 2'b00);
    e.waits = e.err ? 1 : ws_of(d);
    e.rdata = 32'd0;
    if (!e.err) begin
      if (wr) begin
        for (int k = 0; k < (1 << sz); k++) begin
          b = int'(a[1:0]) + k;
          ref_mem[d][a[11:2]][8*b +: 8] = wd[8*b +: 8];
        end
      end else begin
        e.rdata = ref_mem[d][a[11:2]];
      end
    end
    sb.push_back(e);
  endtask

  // One address phase; returns just after the edge that accepts it, with
  // HWDATA then driven for that transfer's data phase.
  task automatic phase(logic sel, logic [1:0] tr, logic [31:0] a, logic wr,
                       logic [2:0] sz, logic [31:0] wd, logic push, int stall_cyc);
    logic ok;
    int   n;
    hsel_bus = sel; htrans = tr; haddr = a; hwrite = wr; hsize = sz;
    if (push && sel && tr[1]) model_push(cur, a, wr, sz, wd);
    if (stall_cyc > 0) begin
      stall = 1'b1;
      repeat (stall_cyc) begin @(posedge clk); #1; end
      stall = 1'b0;
    end
    ok = 1'b0;
    n  = 0;
    while (!ok) begin
      @(negedge clk);
      ok = hready;
      @(posedge clk);
      #1;
      n++;
      if (!ok && n > 40) begin
        check("accept_timeout", 64'd0, 64'd1);
        ok = 1'b1;
      end
    end
    hwdata = wr ? wd : $urandom;
  endtask

  task automatic idle();
    phase(1'b0, 2'b00, 32'd0, 1'b0, 3'd0, 32'd0, 1'b0, 0);
  endtask

  task automatic wr(logic [31:0] a, logic [2:0] sz, logic [31:0] d);
    phase(1'b1, 2'b10, a, 1'b1, sz, d, 1'b1, 0);
  endtask

  task automatic rd(logic [31:0] a, logic [2:0] sz);
    phase(1'b1, 2'b10, a, 1'b0, sz, 32'd0, 1'b1, 0);
  endtask

  task automatic select_dut(int d);
    idle();
    cur = d;
  endtask

  task automatic rand_phase();
    int          r;
    logic [31:0] a;
    logic [2:0]  sz;
    logic [1:0]  tr;
    r = $urandom_range(0, 99);
    if (r < 6) begin
      phase(1'b1, 2'b00, $urandom, 1'b1, 3'd2, $urandom, 1'b1, 0);
    end else if (r < 10) begin
      phase(1'b1, 2'b01, $urandom, 1'b1, 3'd2, $urandom, 1'b1, 0);
    end else if (r < 14) begin
      phase(1'b0, 2'b10, $urandom, 1'b1, 3'd2, $urandom, 1'b1, 0);
    end else begin
      sz = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      case ($urandom_range(0, 9))
        0:          a = 32'h1000 + $urandom_range(0, 4095);
        1:          a = $urandom | 32'h8000_0000;
        2, 3, 4, 5: a = $urandom_range(0, 63);
        default:    a = 32'hFC0 + $urandom_range(0, 63);
      endcase
      if ($urandom_range(0, 9) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      tr = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b11;
      phase(1'b1, tr, a, 1'($urandom_range(0, 1)), sz, $urandom, 1'b1, 0);
    end
  endtask

  // Reset lands in the first cycle after the write's address phase: the WAIT
  // cycle on the waited slave, the DONE cycle on the zero-wait slave.
  task automatic reset_mid_write(int d, logic [31:0] a, logic [31:0] wd);
    select_dut(d);
    mon_en = 1'b0;
    phase(1'b1, 2'b10, a, 1'b1, 3'd2, wd, 1'b0, 0);
    hsel_bus = 1'b0;
    htrans   = 2'b00;
    rst_n    = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_abort_outputs", {30'd0, cur_out()}, {30'd0, 1'b1, 1'b0, 32'd0});
    @(posedge clk); #1;
    mon_en = 1'b1;
    rd(a, 3'd2);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: measure each data phase of the selected slave, compare on
  // completion against the scoreboard head.
  // ---------------------------------------------------------------------------
  int   lows;
  logic saw0, saw1;
  always @(negedge clk) begin
    logic [33:0] o;
    exp_t        e;
    if (!mon_en) begin
      dp_active = 1'b0;
    end else begin
      o = cur_out();
      if (dp_active) begin
        if (!o[33]) begin
          lows++;
          if (o[32]) saw1 = 1'b1; else saw0 = 1'b1;
          if (lows > 20) begin
            check("data_phase_timeout", 64'd0, 64'd1);
            dp_active = 1'b0;
          end
        end else begin
          if (sb.size() == 0) begin
            check("scoreboard_underflow", 64'd1, 64'd0);
          end else begin
            e = sb.pop_front();
            check("wait_cycles", 64'(lows), 64'(e.waits));
            check("hresp_final", {63'd0, o[32]}, {63'd0, e.err});
            check("hresp_during_wait", {63'd0, e.err ? saw0 : saw1}, 64'd0);
            check("hrdata", {32'd0, o[31:0]}, {32'd0, e.rdata});
          end
          dp_active = 1'b0;
        end
      end else begin
        check("idle_outputs", {30'd0, o}, {30'd0, 1'b1, 1'b0, 32'd0});
      end
      if (hsel_bus && htrans[1] && hready) begin
        dp_active = 1'b1;
        lows = 0;
        saw0 = 1'b0;
        saw1 = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst_n = 1'b0; stall = 1'b0; cur = 0; mon_en = 1'b0;
    hsel_bus = 1'b0; htrans = 2'b00; haddr = 32'd0; hwrite = 1'b0;
    hsize = 3'd0; hwdata = 32'd0;

    // Reset held for three rising edges, outputs checked after each one
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_hold", {30'd0, ro0, rp0, rd0}, {30'd0, 1'b1, 1'b0, 32'd0});
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_first_after", {30'd0, ro0, rp0, rd0}, {30'd0, 1'b1, 1'b0, 32'd0});
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Give both slaves a known image in the low and high address windows
    for (int d = 0; d < 2; d++) begin
      select_dut(d);
      for (int w = 0; w < 16; w++)      wr(32'(4 * w), 3'd2, $urandom);
      for (int w = 1008; w < 1024; w++) wr(32'(4 * w), 3'd2, $urandom);
    end

    // Waited slave: word write/read, byte and halfword lanes, errors
    select_dut(0);
    wr(32'h10, 3'd2, 32'hDEADBEEF);
    rd(32'h10, 3'd2);
    wr(32'h10, 3'd2, 32'h0000_0000);
    wr(32'h13, 3'd0, 32'hA500_0000);
    rd(32'h10, 3'd2);
    wr(32'h12, 3'd1, 32'h1234_0000);
    rd(32'h10, 3'd2);
    rd(32'h0000_1000, 3'd2);
    wr(32'h01, 3'd1, 32'hFFFF_FFFF);
    wr(32'h0000_1000, 3'd2, 32'hFFFF_FFFF);
    rd(32'h00, 3'd2);
    rd(32'h00, 3'd3);
    rd(32'hFFC, 3'd2);
    // Address phase held while another slave stalls the bus
    idle();
    phase(1'b1, 2'b10, 32'h10, 1'b0, 3'd2, 32'd0, 1'b1, 3);

    // Zero-wait slave: pipelined write then read of the same word
    select_dut(1);
    wr(32'h20, 3'd2, 32'h1111_1111);
    rd(32'h20, 3'd2);
    wr(32'h24, 3'd0, 32'h0000_7700);
    wr(32'h25, 3'd0, 32'h0000_6600);
    rd(32'h24, 3'd2);
    wr(32'h26, 3'd1, 32'hBEEF_0000);
    rd(32'h24, 3'd2);
    rd(32'h02, 3'd2);
    rd(32'h04, 3'd2);

    for (int d = 0; d < 2; d++) begin
      select_dut(d);
      repeat (250) rand_phase();
    end

    reset_mid_write(0, 32'h30, 32'hCAFE_F00D);
    reset_mid_write(1, 32'h30, 32'hCAFE_F00D);

    idle();
    idle();
    for (int i = 0; i < 50 && (sb.size() != 0 || dp_active); i++) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
